// File: rtl/pixel_pkg.sv
// Shared pixel types, widths and Sobel helpers.
// Reused by the line buffer, edge detector and output stage.
package pixel_pkg;

  localparam int PIX_W       = 8;
  localparam int CNT_W       = 11;
  localparam int COL_NUM_DEF = 320;

  localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [9:0]       sum_t;
  typedef logic [10:0]      mag_t;

  // Window indexed [row][col]: row 0 is the top row, col 2 the newest column.
  typedef pix_t [2:0][2:0] win_t;

  typedef struct packed {
    logic vld;
    sum_t gxp;
    sum_t gxn;
    sum_t gyp;
    sum_t gyn;
  } s1_t;

  typedef struct packed {
    logic vld;
    sum_t ax;
    sum_t ay;
  } s2_t;

  function automatic sum_t tap3(pix_t a, pix_t b, pix_t c);
    return sum_t'(a) + {1'b0, b, 1'b0} + sum_t'(c);
  endfunction

  function automatic sum_t adiff(sum_t a, sum_t b);
    return (a >= b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Registered Sobel datapath: partial sums, absolute values, threshold.
// Valid tags ride alongside the data; every stage advances each cycle.
module sobel_kernel
  import pixel_pkg::*;
#(
  parameter int THRESHOLD = 40
) (
  input  logic sclk,
  input  logic rst_n,
  input  win_t win,
  input  logic win_vld,
  output pix_t po_data,
  output logic po_flag
);

  localparam mag_t THR = mag_t'(THRESHOLD);

  s1_t  s1;
  s2_t  s2;
  mag_t mag;

  assign mag = {1'b0, s2.ax} + {1'b0, s2.ay};

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1.vld <= win_vld;
      s1.gxp <= tap3(win[0][2], win[1][2], win[2][2]);
      s1.gxn <= tap3(win[0][0], win[1][0], win[2][0]);
      s1.gyp <= tap3(win[0][0], win[0][1], win[0][2]);
      s1.gyn <= tap3(win[2][0], win[2][1], win[2][2]);
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      s2 <= '0;
    end else begin
      s2.vld <= s1.vld;
      s2.ax  <= adiff(s1.gxp, s1.gxn);
      s2.ay  <= adiff(s1.gyp, s1.gyn);
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      po_flag <= 1'b0;
      po_data <= EDGE_OFF;
    end else begin
      po_flag <= s2.vld;
      if (s2.vld) begin
        po_data <= (mag >= THR) ? EDGE_ON : EDGE_OFF;
      end
    end
  end

endmodule

// File: rtl/sobel_3x3.sv
// Builds a 3x3 window from the line-buffer row stream and
// emits a thresholded Sobel edge pixel per interior column.
module sobel_3x3
  import pixel_pkg::*;
#(
  parameter int COL_NUM   = COL_NUM_DEF,
  parameter int THRESHOLD = 40
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [7:0] mat_row1,
  input  logic [7:0] mat_row2,
  input  logic [7:0] mat_row3,
  input  logic       mat_flag,
  output logic [7:0] po_data,
  output logic       po_flag
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COL_NUM - 1);
  localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);

  logic             in_vld;
  logic             win_vld;
  logic [CNT_W-1:0] col_cnt;
  win_t             win;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld  <= 1'b0;
      win_vld <= 1'b0;
      col_cnt <= '0;
      win     <= '0;
    end else begin
      in_vld  <= mat_flag;
      // A row's first two captures only prime the window.
      win_vld <= in_vld && (col_cnt >= TWO);
      if (in_vld) begin
        win[0]  <= {mat_row1, win[0][2], win[0][1]};
        win[1]  <= {mat_row2, win[1][2], win[1][1]};
        win[2]  <= {mat_row3, win[2][2], win[2][1]};
        col_cnt <= (col_cnt == LAST) ? '0 : col_cnt + 1'b1;
      end
    end
  end

  sobel_kernel #(
    .THRESHOLD(THRESHOLD)
  ) u_kernel (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .win    (win),
    .win_vld(win_vld),
    .po_data(po_data),
    .po_flag(po_flag)
  );

endmodule

// File: tb/tb_sobel_3x3.sv
// Directed bench for sobel_3x3 with COL_NUM=8, THRESHOLD=40.
module tb_sobel_3x3;

  localparam int NC = 8;

  logic       sclk;
  logic       rst_n;
  logic [7:0] mat_row1, mat_row2, mat_row3;
  logic       mat_flag;
  logic [7:0] po_data;
  logic       po_flag;

  int n_chk;
  int n_err;
  int cyc;
  int col;
  logic [7:0] nr1, nr2, nr3;

  logic [7:0] gq[$];
  int         tq[$];
  int         exp_t[$];

  sobel_3x3 #(
    .COL_NUM  (NC),
    .THRESHOLD(40)
  ) dut (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .mat_row1(mat_row1),
    .mat_row2(mat_row2),
    .mat_row3(mat_row3),
    .mat_flag(mat_flag),
    .po_data (po_data),
    .po_flag (po_flag)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  always @(negedge sclk) begin
    if (po_flag) begin
      gq.push_back(po_data);
      tq.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pxv(int mode, int r, int c);
    case (mode)
      0:       return 8'd100;
      1:       return (c >= 5) ? 8'd200 : 8'd0;
      2:       return (c >= 5) ? 8'd10 : 8'd0;
      3:       return (c >= 5) ? 8'd9 : 8'd0;
      4:       return (r == 0) ? 8'd0 : 8'd50;
      default: return 8'd0;
    endcase
  endfunction

  // Data follows its strobe by one cycle.
  task automatic drive(input logic f, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c);
    @(negedge sclk);
    mat_row1 = nr1;
    mat_row2 = nr2;
    mat_row3 = nr3;
    mat_flag = f;
    if (f) begin
      nr1 = a;
      nr2 = b;
      nr3 = c;
      if (col >= 2) exp_t.push_back(cyc);
      col = (col + 1) % NC;
    end
  endtask

  task automatic send_row(input int mode, input int gap);
    for (int c = 0; c < NC; c++) begin
      drive(1'b1, pxv(mode, 0, c), pxv(mode, 1, c), pxv(mode, 2, c));
      for (int g = 0; g < gap; g++) drive(1'b0, 8'd0, 8'd0, 8'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic verify(input string tag, input int rows,
                        input logic [5:0] emask);
    int n;
    int m;
    logic [7:0] ev;
    idle(10);
    n = rows * (NC - 2);
    check($sformatf("%s_count", tag), gq.size(), n);
    m = (gq.size() < n) ? gq.size() : n;
    for (int i = 0; i < m; i++) begin
      ev = emask[i % (NC - 2)] ? 8'hFF : 8'h00;
      check($sformatf("%s_data%0d", tag, i), gq[i], ev);
      check($sformatf("%s_lat%0d", tag, i), tq[i], exp_t[i] + 5);
    end
    gq.delete();
    tq.delete();
    exp_t.delete();
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    cyc      = 0;
    col      = 0;
    nr1      = 0;
    nr2      = 0;
    nr3      = 0;
    mat_row1 = 0;
    mat_row2 = 0;
    mat_row3 = 0;
    mat_flag = 0;
    rst_n    = 0;
    repeat (3) @(negedge sclk);
    check("rst_data", po_data, 8'h00);
    check("rst_flag", po_flag, 1'b0);
    rst_n = 1;
    idle(2);

    for (int r = 0; r < 3; r++) send_row(0, 0);
    verify("flat", 3, 6'b000000);

    for (int r = 0; r < 2; r++) send_row(1, 0);
    verify("vstep", 2, 6'b011000);

    send_row(2, 0);
    verify("thr40", 1, 6'b011000);

    send_row(3, 0);
    verify("thr36", 1, 6'b000000);

    for (int r = 0; r < 2; r++) send_row(4, 0);
    verify("hstep", 2, 6'b111111);

    for (int r = 0; r < 2; r++) send_row(1, 2);
    verify("gap", 2, 6'b011000);

    for (int c = 0; c < 4; c++) drive(1'b1, 8'd255, 8'd255, 8'd0);
    @(negedge sclk);
    mat_flag = 0;
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("mid_rst_flag%0d", i), po_flag, 1'b0);
      check($sformatf("mid_rst_data%0d", i), po_data, 8'h00);
      @(negedge sclk);
    end
    gq.delete();
    tq.delete();
    exp_t.delete();
    col = 0;
    rst_n = 1;
    idle(8);
    check("no_stale", gq.size(), 0);
    send_row(1, 0);
    verify("restart", 1, 6'b011000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
